// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-side controllers: copier FSM state
// encoding and per-word cycle cost.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned WORD_CYCLES = 3;

endpackage

// File: rtl/copy_index_counter.sv
// Word index for the block copier: clearable, incrementable, and flags the
// last word of the transfer.
module copy_index_counter #(
  parameter int unsigned addrSize = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic [addrSize-1:0] len_i,
  output logic [addrSize-1:0] idx_o,
  output logic                last_o
);

  logic [addrSize-1:0] idx_q;
  logic [addrSize-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + addrSize'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  // Only meaningful while len_i is non-zero; a zero-length copy never reaches WR.
  assign last_o = (idx_q == (len_i - addrSize'(1)));

endmodule

// File: rtl/mem_block_copier.sv
// Copies a block of words through the single-port memory (RD, LAT, WR per
// word) and accumulates a modular checksum of the words moved.
module mem_block_copier
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned addrSize = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [addrSize-1:0] srcBase,
  input  logic [addrSize-1:0] dstBase,
  input  logic [addrSize-1:0] len,
  output logic                busy,
  output logic                done,
  output logic [width-1:0]    checksum,
  output logic [addrSize-1:0] memAddr,
  output logic                memWrite,
  output logic [width-1:0]    memWrData,
  input  logic [width-1:0]    memRdData
);

  state_t              state_q, state_d;
  logic [addrSize-1:0] src_q, dst_q, len_q;
  logic [width-1:0]    buf_q, sum_q;
  logic [addrSize-1:0] idx;
  logic                last;
  logic                accept;
  logic                inc;

  assign accept = (state_q == IDLE) && start;
  assign inc    = (state_q == WR) && !last;

  copy_index_counter #(
    .addrSize(addrSize)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .inc_i (inc),
    .len_i (len_q),
    .idx_o (idx),
    .last_o(last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : RD;
      RD:      state_d = LAT;
      LAT:     state_d = WR;
      WR:      state_d = last ? DONE : RD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      buf_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      src_q <= srcBase;
      dst_q <= dstBase;
      len_q <= len;
      sum_q <= '0;
    end else if (state_q == LAT) begin
      buf_q <= memRdData;
      sum_q <= sum_q + memRdData;
    end
  end

  // Outputs depend only on registered state, never on the inputs directly.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    memWrite = (state_q == WR);
    memAddr  = '0;
    case (state_q)
      RD:      memAddr = src_q + idx;
      WR:      memAddr = dst_q + idx;
      default: memAddr = '0;
    endcase
  end

  assign memWrData = buf_q;
  assign checksum  = sum_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: table-driven directed copies, hand-written
// corner sequences and randomized copies against an array-level model.
module tb_mem_block_copier;
  import mem_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] srcBase = '0, dstBase = '0, len = '0;
  logic       busy, done, memWrite;
  logic [7:0] checksum, memAddr, memWrData;
  logic [7:0] memRdData = '0;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] src, dst, len;
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] exp_sum;
    int         exp_cyc;
    int         exp_wr;
  } vec_t;

  mem_block_copier #(.width(8), .addrSize(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .srcBase  (srcBase),
    .dstBase  (dstBase),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .memAddr  (memAddr),
    .memWrite (memWrite),
    .memWrData(memWrData),
    .memRdData(memRdData)
  );

  always #5 clk = ~clk;

  // One-cycle-latency read, edge-committed write memory.
  always @(posedge clk) begin
    if (memWrite) mem[memAddr] <= memWrData;
    memRdData <= mem[memAddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int idx, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, got, exp);
    end
  endtask

  // Sequential word-by-word copy in ascending order; returns the modular sum.
  function automatic logic [7:0] ref_copy(input int s, input int d, input int l);
    logic [7:0] acc;
    logic [7:0] v;
    acc = '0;
    for (int i = 0; i < l; i++) begin
      v = exp_mem[(s + i) % 256];
      exp_mem[(d + i) % 256] = v;
      acc = acc + v;
    end
    return acc;
  endfunction

  function automatic int mem_diff();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic check_reset_outputs(input int idx);
    check("rst_busy", idx, busy, 0);
    check("rst_done", idx, done, 0);
    check("rst_memWrite", idx, memWrite, 0);
    check("rst_memAddr", idx, memAddr, 0);
    check("rst_memWrData", idx, memWrData, 0);
    check("rst_checksum", idx, checksum, 0);
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          output int cyc, output int wr, output int bsy,
                          output logic [7:0] sum, output logic ok, output logic idle_ok);
    cyc = 0; wr = 0; bsy = 0; sum = '0; ok = 1'b0; idle_ok = 1'b0;
    @(negedge clk);
    srcBase = s; dstBase = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcBase = 8'($urandom); dstBase = 8'($urandom); len = 8'($urandom);
    for (int n = 1; n <= 200; n++) begin
      if (busy) bsy++;
      if (memWrite) wr++;
      if (done) begin
        cyc = n; sum = checksum; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    idle_ok = !busy && !done;
  endtask

  initial begin
    vec_t       vecs [6];
    int         cyc, wr, bsy, ndone, dcyc;
    logic [7:0] sum, rsum, s, d, l;
    logic       ok, idle_ok;

    vecs[0] = '{8'h10, 8'h40, 8'd4, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 13, 4};
    vecs[1] = '{8'h30, 8'h50, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0};
    vecs[2] = '{8'hFE, 8'h20, 8'd3, 8'h01, 8'h02, 8'h03, 8'h00, 8'h06, 10, 3};
    vecs[3] = '{8'h60, 8'hFF, 8'd2, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'hFF, 7, 2};
    vecs[4] = '{8'h05, 8'h06, 8'd3, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h1E, 10, 3};
    vecs[5] = '{8'h80, 8'h90, 8'd4, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00, 13, 4};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    #3;
    check_reset_outputs(0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].len > 0) mem[vecs[k].src]          = vecs[k].d0;
      if (vecs[k].len > 1) mem[8'(vecs[k].src + 1)]  = vecs[k].d1;
      if (vecs[k].len > 2) mem[8'(vecs[k].src + 2)]  = vecs[k].d2;
      if (vecs[k].len > 3) mem[8'(vecs[k].src + 3)]  = vecs[k].d3;
      exp_mem = mem;
      rsum = ref_copy(vecs[k].src, vecs[k].dst, vecs[k].len);
      run_copy(vecs[k].src, vecs[k].dst, vecs[k].len, cyc, wr, bsy, sum, ok, idle_ok);
      check("vec_done_seen", k, ok, 1);
      check("vec_done_cycle", k, cyc, vecs[k].exp_cyc);
      check("vec_writes", k, wr, vecs[k].exp_wr);
      check("vec_busy_cycles", k, bsy, vecs[k].exp_cyc);
      check("vec_checksum", k, sum, vecs[k].exp_sum);
      check("vec_checksum_model", k, sum, rsum);
      check("vec_mem_diffs", k, mem_diff(), 0);
      check("vec_idle_after", k, idle_ok, 1);
    end

    // Second start at cycle 5 of a len=4 copy must be ignored.
    mem[8'h10] = 8'hC1; mem[8'h11] = 8'hC2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hC4;
    exp_mem = mem;
    rsum = ref_copy(8'h10, 8'h40, 4);
    @(negedge clk);
    srcBase = 8'h10; dstBase = 8'h40; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        ndone++;
        if (dcyc == 0) dcyc = c;
      end
      if (c == 5) begin
        start = 1'b1; srcBase = 8'h70; dstBase = 8'hC0; len = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 0, ndone, 1);
    check("busy_start_done_cycle", 0, dcyc, 13);
    check("busy_start_mem_diffs", 0, mem_diff(), 0);
    check("busy_start_checksum", 0, checksum, rsum);

    // Asynchronous reset during the WR cycle of word 2.
    mem[8'h10] = 8'hB1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hB3; mem[8'h13] = 8'hB4;
    mem[8'h40] = 8'hEE; mem[8'h41] = 8'hEE; mem[8'h42] = 8'hEE; mem[8'h43] = 8'hEE;
    @(negedge clk);
    srcBase = 8'h10; dstBase = 8'h40; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 9; c++) @(negedge clk);
    check("midrst_wr_before", 0, memWrite, 1);
    check("midrst_addr_before", 0, memAddr, 8'h42);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(1);
    @(negedge clk);
    check_reset_outputs(2);
    rst_n = 1'b1;
    check("midrst_word0", 0, mem[8'h40], 8'hB1);
    check("midrst_word1", 0, mem[8'h41], 8'hB2);
    check("midrst_word2", 0, mem[8'h42], 8'hEE);
    check("midrst_word3", 0, mem[8'h43], 8'hEE);

    exp_mem = mem;
    rsum = ref_copy(8'h10, 8'h80, 3);
    run_copy(8'h10, 8'h80, 8'd3, cyc, wr, bsy, sum, ok, idle_ok);
    check("postrst_done_seen", 0, ok, 1);
    check("postrst_done_cycle", 0, cyc, 10);
    check("postrst_checksum", 0, sum, rsum);
    check("postrst_mem_diffs", 0, mem_diff(), 0);

    // Randomized copies, back to back.
    for (int r = 0; r < 20; r++) begin
      s = 8'($urandom);
      d = 8'($urandom);
      l = 8'($urandom_range(0, 12));
      exp_mem = mem;
      rsum = ref_copy(s, d, l);
      run_copy(s, d, l, cyc, wr, bsy, sum, ok, idle_ok);
      check("rnd_done_seen", r, ok, 1);
      check("rnd_done_cycle", r, cyc, WORD_CYCLES * l + 1);
      check("rnd_writes", r, wr, l);
      check("rnd_busy_cycles", r, bsy, WORD_CYCLES * l + 1);
      check("rnd_checksum", r, sum, rsum);
      check("rnd_mem_diffs", r, mem_diff(), 0);
      check("rnd_idle_after", r, idle_ok, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_block_copier.md
# mem_block_copier

Initiator for the single-port word memory: on a start pulse it copies `len` consecutive words from `srcBase` to `dstBase` by driving the memory's addr/write/wrData port and sampling its rdData. It also accumulates a modular checksum of the copied words. It sits between the datapath controller and the memory, which it treats as a one-cycle-latency read, edge-committed write responder.

## Interface
- `width`, 8, data word width in bits
- `addrSize`, 8, memory address width in bits

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `srcBase`  in  addrSize  first source address; sampled with start
- `dstBase`  in  addrSize  first destination address; sampled with start
- `len`  in  addrSize  word count, 0 allowed; sampled with start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `checksum`  out  width  sum of copied words mod 2^width; valid from done onward
- `memAddr`  out  addrSize  memory address
- `memWrite`  out  1  memory write enable
- `memWrData`  out  width  memory write data
- `memRdData`  in  width  memory read data

## Operation
- States: IDLE, RD, LAT, WR, DONE. Encoding is 3-bit: 0, 1, 2, 3, 4.
- IDLE:
  - If `start`=1, latch `srcBase`, `dstBase` and `len`, clear the index and `checksum`.
  - Then go to DONE if `len`=0, else to RD.
- RD: `memAddr`=src+idx, `memWrite`=0. Next state is LAT.
- LAT: capture `memRdData` into the word buffer and add it to `checksum`. Next state is WR.
- WR:
  - `memAddr`=dst+idx, `memWrite`=1, `memWrData`=buffer.
  - If idx=len-1, go to DONE; else idx+1 and go to RD.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Address arithmetic is addrSize bits and wraps modulo 2^addrSize. Example: src=FE, len=3 reads FE, FF, 00.
- `checksum` is a width-bit sum and wraps silently.
- Overlapping regions are copied in ascending order. If dst>src and the regions overlap, the copy propagates source data forward; this is the defined behaviour, not an error.
- `start` while busy is ignored and not queued. Changes to `srcBase`/`dstBase`/`len` after acceptance have no effect.
- `memWrite` is high only in WR.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; `busy`=0, `done`=0, `memWrite`=0, `memAddr`=0, `memWrData`=0, `checksum`=0.
  - Index and buffer are cleared.
- Reset mid-copy aborts the copy. No further writes occur; words already written stay in memory.
- Memory contract: `memRdData` reflects `memAddr` by the end of the cycle following the RD cycle. A write commits at the rising edge that ends the WR cycle.
- Each word costs 3 cycles (RD, LAT, WR).
- Let E0 be the edge at which `start` is accepted. `done` is high in the cycle after edge E0+3·len, so len=0 gives `done` in the cycle right after E0.
- `busy` rises the cycle after E0 and falls together with `done`.
- Back-to-back copies: a new `start` is accepted at the edge ending the cycle after DONE (the first IDLE cycle).

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - the state typedef and encoding above;
  - localparam `WORD_CYCLES`=3.
- One sub-module, `copy_index_counter`:
  - addrSize-bit index with clear, increment, and a terminal flag (idx==len-1).
  - Instanced once; the FSM lives in `mem_block_copier`.

## Test plan
- Basic copy:
  - Setup: memory[10..13]=11,22,33,44; src=10, dst=40, len=4.
  - Expected: memory[40..43]=11,22,33,44; `checksum`=AA; `done` 13 cycles after E0; exactly 4 cycles with `memWrite`=1.
- len=0:
  - Expected: `done` the cycle after E0, `busy` high for 1 cycle, no `memWrite`, `checksum`=0.
- Address wrap:
  - Setup: memory[FE,FF,00]=01,02,03; src=FE, dst=20, len=3.
  - Expected: memory[20..22]=01,02,03.
  - Also: dst=FF, len=2 writes FF then 00.
- Forward overlap:
  - Setup: memory[5..7]=A,B,C; src=5, dst=6, len=3.
  - Expected: memory[6..8]=A,A,A.
- Start during busy:
  - Stimulus: second `start` pulse with different args at cycle 5 of a len=4 copy.
  - Expected: ignored; only the first copy executes; one `done`.
- Reset mid-copy:
  - Stimulus: `rst_n` low during WR of word 2 of len=4 (async, between edges).
  - Expected: `memWrite` drops immediately; all outputs at reset values; words 0–1 written, words 2–3 untouched.
  - Then: a new `start` after reset completes normally.
